// File: rtl/sub_pkg.sv
// Shared definitions for the serial borrow-lookahead subtractor.
//   SLICE_W  : bits processed per clock.
//   state_t  : controller states IDLE / RUN / DONE.
//   cnt_w()  : width of the slice counter for a given operand width
//              (ceil(log2(width/SLICE_W)), never less than 1).
package sub_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned cnt_w(input int unsigned width);
    int unsigned n;
    int unsigned w;
    n = width / SLICE_W;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << w) < n) w = w + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/sub_4_bit.sv
// Combinational 4-bit borrow-lookahead subtractor slice: d = a - b - borrow_in.
// Ports:
//   a, b       : 4-bit operand slices (minuend, subtrahend)
//   borrow_in  : borrow into the slice
//   d          : 4-bit difference
//   borrow_out : borrow out of the slice
//   g_out      : group borrow-generate (slice borrows regardless of borrow_in)
//   p_out      : group borrow-propagate (slice passes borrow_in through)
module sub_4_bit
  import sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               borrow_in,
  output logic [SLICE_W-1:0] d,
  output logic               borrow_out,
  output logic               g_out,
  output logic               p_out
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   bw;

  // A bit borrows when a=0,b=1; it passes an incoming borrow when a==b.
  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Lookahead borrows, each expanded directly from borrow_in.
  assign bw[0] = borrow_in;
  assign bw[1] = g[0] | (p[0] & borrow_in);
  assign bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & borrow_in);
  assign bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & borrow_in);

  assign g_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
  assign p_out = &p;

  assign bw[4]      = g_out | (p_out & borrow_in);
  assign borrow_out = bw[4];

  assign d = a ^ b ^ bw[SLICE_W-1:0];

endmodule

// File: rtl/sub_serial_cla.sv
// Multi-cycle subtractor: d = a - b - borrow_in over WIDTH bits, one 4-bit
// borrow-lookahead slice per clock, least significant slice first.
// Optional feature macro: SUB_SIGNED_OVF_EN (adds the signed overflow flag ovf).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake (in_ready high only in IDLE)
//   a, b, borrow_in      : operands and incoming borrow
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   d                    : difference mod 2^WIDTH (qualify with out_valid)
//   borrow_out           : 1 iff a < b + borrow_in (unsigned)
//   zero                 : 1 iff d == 0
//   ovf                  : signed overflow (only with SUB_SIGNED_OVF_EN)
module sub_serial_cla
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow_out,
  output logic             zero
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N    = WIDTH / SLICE_W;
  localparam int unsigned CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("sub_serial_cla: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_t             state;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               borrow_r;
  logic [CW-1:0]      cnt;

  int unsigned        base;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_d;
  logic               slice_bo;
  logic               slice_g;
  logic               slice_p;
  logic               borrow_nxt;
  logic [WIDTH-1:0]   d_next;

  always_comb begin
    base    = 32'(cnt) * SLICE_W;
    slice_a = a_r[base +: SLICE_W];
    slice_b = b_r[base +: SLICE_W];
  end

  sub_4_bit u_slice (
    .a          (slice_a),
    .b          (slice_b),
    .borrow_in  (borrow_r),
    .d          (slice_d),
    .borrow_out (slice_bo),
    .g_out      (slice_g),
    .p_out      (slice_p)
  );

  // Running inter-slice borrow uses the group terms; the final flag takes the
  // slice's own borrow output. Both are the same function of borrow_r.
  always_comb begin
    borrow_nxt             = slice_g | (slice_p & borrow_r);
    d_next                 = d;
    d_next[base +: SLICE_W] = slice_d;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      borrow_r   <= 1'b0;
      cnt        <= '0;
      d          <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= borrow_in;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          d        <= d_next;
          borrow_r <= borrow_nxt;
          if (cnt == LAST) begin
            borrow_out <= slice_bo;
            zero       <= (d_next == '0);
`ifdef SUB_SIGNED_OVF_EN
            ovf        <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                          (d_next[WIDTH-1] != a_r[WIDTH-1]);
`endif
            state      <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial_cla.sv
module tb_sub_serial_cla;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         borrow_out;
  logic         zero;
`ifdef SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  sub_serial_cla #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .d          (d),
    .borrow_out (borrow_out),
    .zero       (zero)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         ov;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    exp_t     e;
    logic [W:0] diff;
    diff = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
    e.d  = diff[W-1:0];
    e.bo = diff[W];
    e.z  = (diff[W-1:0] == '0);
    e.ov = (av[W-1] != bv[W-1]) && (diff[W-1] != av[W-1]);
    return e;
  endfunction

  // Drive one request; returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                      input logic push);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    a         = av;
    b         = bv;
    borrow_in = bi;
    in_valid  = 1'b1;
    if (push) sb_q.push_back(model(av, bv, bi));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the result, optionally stall, compare against the scoreboard.
  task automatic collect(input int stall, input logic poke, input logic chk_lat);
    int           lat;
    logic [W-1:0] d0;
    logic         stable;
    exp_t         e;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (chk_lat) check("latency", lat, W / 4);
    d0     = d;
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        a         = W'($urandom);
        b         = W'($urandom);
        in_valid  = 1'b1;
      end
      @(negedge clk);
      if (!out_valid || d !== d0 || in_ready) stable = 1'b0;
    end
    in_valid = 1'b0;
    if (stall > 0) check("stall_stable", stable, 1);
    if (sb_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check("d", d, e.d);
      check("borrow_out", borrow_out, e.bo);
      check("zero", zero, e.z);
`ifdef SUB_SIGNED_OVF_EN
      check("ovf", ovf, e.ov);
`endif
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ready_after", in_ready, 1);
    check("valid_after", out_valid, 0);
  endtask

  initial begin
    logic saw_valid;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_d", d, 0);
    check("rst_borrow", borrow_out, 0);
    check("rst_zero", zero, 0);
`ifdef SUB_SIGNED_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    send(16'h1234, 16'h0234, 1'b0, 1'b1); collect(0, 1'b0, 1'b1);
    send(16'h0000, 16'h0001, 1'b0, 1'b1); collect(2, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1); collect(0, 1'b0, 1'b1);
    send(16'h0005, 16'h0005, 1'b1, 1'b1); collect(1, 1'b0, 1'b1);
    send(16'h0000, 16'h0000, 1'b0, 1'b1); collect(0, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b1); collect(0, 1'b0, 1'b1);

    // Backpressure with ignored requests while DONE.
    send(16'hABCD, 16'h1234, 1'b1, 1'b1); collect(10, 1'b1, 1'b1);

    // Reset during the second RUN cycle discards the operation.
    send(16'h4444, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_d", d, 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_valid", saw_valid, 0);
    send(16'h0003, 16'h0003, 1'b0, 1'b1); collect(0, 1'b0, 1'b1);

    // Random regression with random result stalls.
    for (int n = 0; n < 3000; n++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      collect(int'($urandom_range(0, 3)), 1'b0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
